// File: rtl/id_ex_skid_pkg.sv
// Shared ID/EX definitions: the NOP word, payload field widths and the payload width formula.
// The payload is packed as {inst, inst_addr, op1, op2, rd_addr, rd_wen}.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

package id_ex_skid_pkg;

    localparam int INST_W      = 32;
    localparam int WEN_W       = 1;
    localparam int XLEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;

    function automatic int payload_w(input int xlen, input int raddr_w);
        return INST_W + 3 * xlen + raddr_w + WEN_W;
    endfunction

    localparam int PAYLOAD_W = payload_w(XLEN_DEF, RADDR_W_DEF);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/id_ex_slot.sv
// One payload register with a valid bit; load sets valid, clear drops it (clear wins over load).
module id_ex_slot
    import id_ex_skid_pkg::*;
#(
    parameter int W = PAYLOAD_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ld_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] q_o
);

    logic         vld_q;
    logic [W-1:0] dat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            if (clr_i) begin
                vld_q <= 1'b0;
            end else if (ld_i) begin
                vld_q <= 1'b1;
            end
            if (ld_i) begin
                dat_q <= d_i;
            end
        end
    end

    assign vld_o = vld_q;
    assign q_o   = dat_q;

endmodule

// File: rtl/id_ex_skid.sv
// Elastic ID/EX stage with 2-entry skid; 1-cycle latency, in_ready registered (!skid valid).
// Flush empties both slots; optional ID_EX_PERF_CNT_EN adds saturating stall/flush counters.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module id_ex_skid
    import id_ex_skid_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          RADDR_W  = 5,
    parameter logic [31:0] NOP_INST = `INST_NOP
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               flush_en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        inst,
    input  logic [XLEN-1:0]    inst_addr,
    input  logic [XLEN-1:0]    op1,
    input  logic [XLEN-1:0]    op2,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic               rd_wen,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        inst_dly,
    output logic [XLEN-1:0]    inst_addr_dly,
    output logic [XLEN-1:0]    op1_dly,
    output logic [XLEN-1:0]    op2_dly,
    output logic [RADDR_W-1:0] rd_addr_dly,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt,
`endif
    output logic               rd_wen_dly
);

    localparam int PW = payload_w(XLEN, RADDR_W);

    skid_state_e state_q, state_d;
    logic          main_ld, main_clr, main_from_skid, skid_ld, skid_clr;
    logic          main_vld, skid_vld;
    logic [PW-1:0] in_pay, main_d, main_q, skid_q;
    logic          accept, consume;

    logic [31:0]        p_inst;
    logic [XLEN-1:0]    p_addr, p_op1, p_op2;
    logic [RADDR_W-1:0] p_rd;
    logic               p_wen;

    assign in_pay  = {inst, inst_addr, op1, op2, rd_addr, rd_wen};
    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (flush_en) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_ld = 1'b1;
                    end else if (consume) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid entry can advance.
                    if (consume) begin
                        state_d        = ST_ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_pay;

    id_ex_slot #(.W(PW)) u_main (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .ld_i  (main_ld),
        .clr_i (main_clr),
        .d_i   (main_d),
        .vld_o (main_vld),
        .q_o   (main_q)
    );

    id_ex_slot #(.W(PW)) u_skid (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .ld_i  (skid_ld),
        .clr_i (skid_clr),
        .d_i   (in_pay),
        .vld_o (skid_vld),
        .q_o   (skid_q)
    );

    assign out_valid = main_vld;
    assign in_ready  = ~skid_vld;

    // Bubbles are forced to NOP form so stale slot contents never reach EX.
    assign {p_inst, p_addr, p_op1, p_op2, p_rd, p_wen} = main_q;
    assign inst_dly      = main_vld ? p_inst : NOP_INST;
    assign inst_addr_dly = main_vld ? p_addr : '0;
    assign op1_dly       = main_vld ? p_op1  : '0;
    assign op2_dly       = main_vld ? p_op2  : '0;
    assign rd_addr_dly   = main_vld ? p_rd   : '0;
    assign rd_wen_dly    = main_vld & p_wen;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_en && flush_cnt_q != 32'hFFFF_FFFF) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// Directed bench for id_ex_skid: reset, streaming, back-pressure, flush, mid-run reset, optional counters.
module tb_id_ex_skid;

    localparam int          XLEN    = 32;
    localparam int          RADDR_W = 5;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic               flush_en;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        inst;
    logic [XLEN-1:0]    inst_addr, op1, op2;
    logic [RADDR_W-1:0] rd_addr;
    logic               rd_wen;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        inst_dly;
    logic [XLEN-1:0]    inst_addr_dly, op1_dly, op2_dly;
    logic [RADDR_W-1:0] rd_addr_dly;
    logic               rd_wen_dly;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]        stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    id_ex_skid #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .flush_en      (flush_en),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .inst          (inst),
        .inst_addr     (inst_addr),
        .op1           (op1),
        .op2           (op2),
        .rd_addr       (rd_addr),
        .rd_wen        (rd_wen),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .inst_dly      (inst_dly),
        .inst_addr_dly (inst_addr_dly),
        .op1_dly       (op1_dly),
        .op2_dly       (op2_dly),
        .rd_addr_dly   (rd_addr_dly),
`ifdef ID_EX_PERF_CNT_EN
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
`endif
        .rd_wen_dly    (rd_wen_dly)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Every payload field is derived from the instruction word so one word identifies a whole entry.
    task automatic drive(input logic v, input logic [31:0] w);
        in_valid  = v;
        inst      = w;
        inst_addr = w + 32'h0000_0100;
        op1       = ~w;
        op2       = {w[15:0], w[31:16]};
        rd_addr   = w[11:7];
        rd_wen    = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] w);
        logic [31:0] a, o1, o2;
        logic [4:0]  rd;
        a  = w + 32'h0000_0100;
        o1 = ~w;
        o2 = {w[15:0], w[31:16]};
        rd = w[11:7];
        chk({tag, "_vld"},  out_valid,     1);
        chk({tag, "_inst"}, inst_dly,      w);
        chk({tag, "_addr"}, inst_addr_dly, a);
        chk({tag, "_op1"},  op1_dly,       o1);
        chk({tag, "_op2"},  op2_dly,       o2);
        chk({tag, "_rd"},   rd_addr_dly,   rd);
        chk({tag, "_wen"},  rd_wen_dly,    1);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_vld"},  out_valid,     0);
        chk({tag, "_rdy"},  in_ready,      1);
        chk({tag, "_inst"}, inst_dly,      NOP);
        chk({tag, "_addr"}, inst_addr_dly, 0);
        chk({tag, "_op1"},  op1_dly,       0);
        chk({tag, "_op2"},  op2_dly,       0);
        chk({tag, "_rd"},   rd_addr_dly,   0);
        chk({tag, "_wen"},  rd_wen_dly,    0);
    endtask

    initial begin
        // Reset for two cycles with a live-looking input that must be ignored.
        sys_rst   = 1'b1;
        flush_en  = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF);
        tick();
        tick();
        chk_empty("rst");
        sys_rst = 1'b0;
        drive(1'b0, 32'h0);
        tick();
        chk_empty("idle");

        // Streaming at full rate.
        drive(1'b1, 32'h0050_0093);
        tick();
        chk_out("s0", 32'h0050_0093);
        chk("s0_rdy", in_ready, 1);
        drive(1'b1, 32'h00A0_0113);
        tick();
        chk_out("s1", 32'h00A0_0113);
        drive(1'b1, 32'h0020_8193);
        tick();
        chk_out("s2", 32'h0020_8193);
        drive(1'b0, 32'h0);
        tick();
        chk_empty("s_end");

        // Back-pressure: A then B fill both slots, C waits upstream.
        out_ready = 1'b0;
        drive(1'b1, 32'h1111_1111);
        tick();
        chk_out("bpA", 32'h1111_1111);
        chk("bpA_rdy", in_ready, 1);
        drive(1'b1, 32'h2222_2222);
        tick();
        chk_out("bpFullA", 32'h1111_1111);
        chk("bpFull_rdy", in_ready, 0);
        drive(1'b1, 32'h3333_3333);
        tick();
        chk_out("bpHoldA", 32'h1111_1111);
        chk("bpHold_rdy", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk_out("bpB", 32'h2222_2222);
        chk("bpB_rdy", in_ready, 1);
        tick();
        chk_out("bpC", 32'h3333_3333);
        drive(1'b0, 32'h0);
        tick();
        chk_empty("bp_end");

        // Flush from FULL with a pending input.
        out_ready = 1'b0;
        drive(1'b1, 32'h4444_4444);
        tick();
        drive(1'b1, 32'h5555_5555);
        tick();
        chk("fl_full_rdy", in_ready, 0);
        flush_en = 1'b1;
        drive(1'b1, 32'h1234_5678);
        tick();
        flush_en = 1'b0;
        drive(1'b0, 32'h0);
        chk_empty("fl_full");
        tick();
        chk_empty("fl_full_after");

        // Flush from ONE while an input is actually accepted in the same cycle.
        out_ready = 1'b1;
        drive(1'b1, 32'h6666_6666);
        tick();
        chk_out("fl1", 32'h6666_6666);
        flush_en = 1'b1;
        drive(1'b1, 32'h1234_5678);
        tick();
        flush_en = 1'b0;
        drive(1'b0, 32'h0);
        chk_empty("fl_one");
        tick();
        chk_empty("fl_one_after");

        // Reset mid-operation while FULL and stalled.
        out_ready = 1'b0;
        drive(1'b1, 32'h7777_7777);
        tick();
        drive(1'b1, 32'h8888_8888);
        tick();
        chk("mr_full_rdy", in_ready, 0);
        sys_rst = 1'b1;
        drive(1'b1, 32'h9999_9999);
        tick();
        sys_rst = 1'b0;
        chk_empty("mr");
        out_ready = 1'b1;
        drive(1'b1, 32'hAAAA_AAAA);
        tick();
        chk_out("mr_next", 32'hAAAA_AAAA);
        drive(1'b0, 32'h0);
        tick();
        chk_empty("mr_end");

`ifdef ID_EX_PERF_CNT_EN
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("pc_rst_stall", stall_cnt, 0);
        chk("pc_rst_flush", flush_cnt, 0);
        out_ready = 1'b0;
        drive(1'b1, 32'hBBBB_BBBB);
        tick();
        drive(1'b0, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("pc_stall5", stall_cnt, 5);
        out_ready = 1'b1;
        flush_en  = 1'b1;
        tick();
        tick();
        flush_en = 1'b0;
        tick();
        chk("pc_stall", stall_cnt, 5);
        chk("pc_flush", flush_cnt, 2);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("pc_clr_stall", stall_cnt, 0);
        chk("pc_clr_flush", flush_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_skid.md
Name: id_ex_skid

Overview:
- Parametrised ID/EX pipeline stage; successor to the fixed-width hold-to-NOP ID/EX register.
- Adds a valid/ready elastic handshake with a 2-entry skid buffer, so a stall from EX no longer destroys the in-flight instruction.
- Separates flush (kill) from stall (back-pressure).
- Sits between the decoder/regfile-read logic and the EX/ALU stage.

Parameters:
- XLEN, 32, width of inst_addr, op1 and op2.
- RADDR_W, 5, register address width.
- NOP_INST, `INST_NOP, instruction word presented when the output is invalid.

Ports:
- sys_clk  in  1  clock; all logic is on the rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- flush_en  in  1  kill all buffered entries (branch/jump redirect).
- in_valid  in  1  the ID stage presents a decoded instruction.
- in_ready  out  1  the stage can accept; registered, equal to !skid_valid.
- inst  in  32  instruction word.
- inst_addr  in  XLEN  instruction PC.
- op1  in  XLEN  operand 1.
- op2  in  XLEN  operand 2.
- rd_addr  in  RADDR_W  destination register.
- rd_wen  in  1  destination write enable.
- out_valid  out  1  the output payload is valid.
- out_ready  in  1  the EX stage consumes the output.
- inst_dly, inst_addr_dly, op1_dly, op2_dly, rd_addr_dly, rd_wen_dly  out  32/XLEN/XLEN/XLEN/RADDR_W/1  output payload.

Behaviour:
- Handshakes
  - Accept happens when in_valid & in_ready.
  - Consume happens when out_valid & out_ready.
  - in_ready does not depend combinationally on out_ready.
- Storage: a main slot (drives the outputs) and a skid slot.
- States
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both valid; in_ready=0.
- Transitions
  - EMPTY + accept -> ONE; main <= input.
  - ONE + accept, no consume -> FULL; skid <= input.
  - ONE + accept + consume -> ONE; main <= input.
  - ONE + consume, no accept -> EMPTY.
  - FULL + consume -> ONE; main <= skid.
  - FULL, no consume -> FULL; both slots hold.
- Timing and ordering
  - Latency: accept in cycle N gives out_valid=1 in cycle N+1 when EMPTY, or ONE with a same-cycle consume.
  - Sustained throughput: 1 instruction/cycle.
  - Strict FIFO order; no duplicate or lost entries.
- Output gating: when out_valid=0, outputs are inst_dly=NOP_INST, rd_wen_dly=0, and all other payload outputs 0, regardless of slot contents. A bubble therefore never writes the register file.
- flush_en=1: next state is EMPTY and both slots are dropped. An input accepted in the same cycle is discarded. Flush beats accept and consume. A consume asserted by EX in the flush cycle is still counted as taken by EX.
- Reset (sys_rst=1 at a clock edge, including mid-transfer):
  - State EMPTY, out_valid=0, in_ready=1, outputs in NOP form.
  - Inputs are ignored during the reset cycle.
- Reset has priority over flush.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds two outputs, stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle with flush_en=1.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both are cleared by sys_rst only; flush does not clear them.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- `INST_NOP, the payload field widths, and a PAYLOAD_W localparam formula (32+3*XLEN+RADDR_W+1) belong in the shared defines file.
- One natural sub-module: id_ex_slot, a PAYLOAD_W-wide register with load enable and valid bit, instantiated twice (main, skid).
- The top level holds the state logic and output gating.

Test Plan:
- Reset then idle: sys_rst=1 for 2 cycles -> out_valid=0, in_ready=1, inst_dly=NOP_INST, rd_wen_dly=0, all other outputs 0.
- Streaming: out_ready=1; push inst 0x00500093, 0x00A00113, 0x00208193 on consecutive cycles -> out_valid high from cycle N+1; same three words emerge in order with one-cycle latency and no gaps.
- Back-pressure: out_ready=0 after the first push; push A and B -> FULL, in_ready=0, C held upstream; raise out_ready -> A, B, C emerge in order with no duplicates.
- Flush: FULL, then flush_en=1 with in_valid=1 (inst 0x12345678) -> next cycle out_valid=0, rd_wen_dly=0, in_ready=1; 0x12345678 never appears at the output.
- Reset mid-operation: FULL with out_ready=0, assert sys_rst for one cycle -> EMPTY, NOP outputs, both slots discarded; next accept appears after one cycle.
- With ID_EX_PERF_CNT_EN: hold out_ready=0 for 5 valid cycles and pulse flush_en twice -> stall_cnt=5, flush_cnt=2; sys_rst clears both.
